// File: rtl/pipeline_pkg.sv
// Shared defaults and helpers for the valid-only pipeline termination blocks.
package pipeline_pkg;

  localparam int PIPE_DATA_WIDTH = 32;
  localparam int PIPE_SINK_DEPTH = 4;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int clog2_plus1(input int n);
    int w;
    w = 0;
    while ((1 << w) < (n + 1)) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipeline_sink_fifo.sv
// Show-ahead circular buffer that captures every pipeline beat; drops and flags
// pushes that arrive while full with no same-cycle pop.
module pipeline_sink_fifo
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int DEPTH      = PIPE_SINK_DEPTH,
  localparam int CNT_W     = clog2_plus1(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_req,
  output logic                  pop_fire,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      occ;
  logic                  fresh;
  logic                  full;
  logic                  empty;
  logic                  push_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (occ == CNT_W'(DEPTH));
  assign empty    = (occ == '0);
  assign pop_fire = ~empty & pop_req;
  assign push_ok  = push & (~full | pop_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      fresh    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= next_ptr(wr_ptr);
        fresh  <= 1'b0;
      end
      if (pop_fire)
        rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push & full & ~pop_fire)
        overflow <= 1'b1;
    end
  end

  // Payload storage carries no reset; the fresh flag masks it until first write.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  assign out_valid = ~empty;
  assign out_data  = fresh ? '0 : mem[rd_ptr];
  assign occupancy = occ;

endmodule

// File: rtl/pipeline_credit_sink.sv
// Terminates a valid-only pipeline: hands out credits at the launch point and
// buffers arriving beats for a ready/valid consumer.
module pipeline_credit_sink
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int DEPTH      = PIPE_SINK_DEPTH,
  localparam int CNT_W     = clog2_plus1(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  input  logic                  pipe_valid,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      credits,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  overflow,
  output logic                  protocol_error
);

  logic debit;
  logic credit_return;

  assign launch_ready = (credits != '0);
  assign debit        = launch_valid & launch_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits        <= CNT_W'(DEPTH);
      protocol_error <= 1'b0;
    end else begin
      credits <= credits - CNT_W'(debit) + CNT_W'(credit_return);
      if (launch_valid & ~launch_ready)
        protocol_error <= 1'b1;
    end
  end

  pipeline_sink_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_valid),
    .push_data (pipe_data),
    .pop_req   (out_ready),
    .pop_fire  (credit_return),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

endmodule
